// File: rtl/watches_sec_min_cnt_if.sv
// rtl/watches_sec_min_cnt_if.sv - user controls and time outputs of the seconds/minutes timebase
interface watches_sec_min_cnt_if;
    logic                    user_min_up_i;
    logic                    user_time_val_i;
    logic [$clog2(59)-1:0]   sec_o;
    logic [$clog2(59)-1:0]   min_o;
    logic                    last_tact_o;

    modport master (
        output user_min_up_i,
        output user_time_val_i,
        input  sec_o,
        input  min_o,
        input  last_tact_o
    );

    modport slave (
        input  user_min_up_i,
        input  user_time_val_i,
        output sec_o,
        output min_o,
        output last_tact_o
    );
endinterface

// File: rtl/watches_sec_min_cnt.sv
// rtl/watches_sec_min_cnt.sv - 1 Hz prescaler with seconds/minutes counters and minute-step button
module watches_sec_min_cnt #(
    parameter int CLK_HZ = 25_000_000,
    parameter int ST_SEC = 0,
    parameter int ST_MIN = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    watches_sec_min_cnt_if.slave   bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int CW = $clog2(59);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [CW-1:0] LAST_VAL  = CW'(59);

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] sec_q, sec_d;
    logic [CW-1:0] min_q, min_d;
    logic          mu_s1_q, mu_s1_d;
    logic          mu_s2_q, mu_s2_d;
    logic          mu_d_q, mu_d_d;
    logic          last_tact;
    logic          min_up_ena;

    // Setting mode masks the tick so the hour stage never advances while time is edited.
    assign last_tact  = (presc_q == PRESC_MAX) & ~bus.user_time_val_i;
    assign min_up_ena = mu_s2_q & ~mu_d_q;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        mu_s1_d = bus.user_min_up_i;
        mu_s2_d = mu_s1_q;
        mu_d_d  = mu_s2_q;
        if (bus.user_time_val_i) begin
            presc_d = '0;
            sec_d   = '0;
            if (min_up_ena) begin
                min_d = (min_q == LAST_VAL) ? '0 : min_q + CW'(1);
            end
        end else if (last_tact) begin
            presc_d = '0;
            if (sec_q == LAST_VAL) begin
                sec_d = '0;
                min_d = (min_q == LAST_VAL) ? '0 : min_q + CW'(1);
            end else begin
                sec_d = sec_q + CW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            sec_q   <= CW'(ST_SEC);
            min_q   <= CW'(ST_MIN);
            mu_s1_q <= 1'b0;
            mu_s2_q <= 1'b0;
            mu_d_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            mu_s1_q <= mu_s1_d;
            mu_s2_q <= mu_s2_d;
            mu_d_q  <= mu_d_d;
        end
    end

    assign bus.sec_o       = sec_q;
    assign bus.min_o       = min_q;
    assign bus.last_tact_o = last_tact;
endmodule

// File: tb/tb_watches_sec_min_cnt.sv
// tb/tb_watches_sec_min_cnt.sv - scoreboard bench for the seconds/minutes timebase (CLK_HZ=4)
module tb_watches_sec_min_cnt;
    typedef struct {
        logic [5:0] sec;
        logic [5:0] min;
        logic       lt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    watches_sec_min_cnt_if ifc ();

    watches_sec_min_cnt #(.CLK_HZ(4), .ST_SEC(58), .ST_MIN(59)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task test_reset;
        exp_t e;
        ifc.user_min_up_i = 1'b0;
        ifc.user_time_val_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ifc.sec_o !== 6'd58) begin bad++; $display("FAIL reset_sec got=%0d exp=58", ifc.sec_o); end
        total++; if (ifc.min_o !== 6'd59) begin bad++; $display("FAIL reset_min got=%0d exp=59", ifc.min_o); end
        total++; if (ifc.last_tact_o !== 1'b0) begin bad++; $display("FAIL reset_lt got=%0b exp=0", ifc.last_tact_o); end
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            e.lt  = (c == 3 || c == 7 || c == 11);
            e.sec = (c < 4) ? 6'd58 : (c < 8) ? 6'd59 : (c < 12) ? 6'd0 : 6'd1;
            e.min = (c < 8) ? 6'd59 : 6'd0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL rel_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL rel_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL rel_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
        end
    endtask

    task test_free_run;
        exp_t e;
        int pulses;
        int viol;
        logic [5:0] ps, pm;
        ifc.user_time_val_i = 1'b1;
        @(negedge clk);
        ifc.user_time_val_i = 1'b0;
        pulses = 0;
        viol = 0;
        ps = ifc.sec_o;
        pm = ifc.min_o;
        for (int c = 1; c <= 14400; c++) begin
            e.lt  = ((c % 4) == 3);
            e.sec = 6'((c / 4) % 60);
            e.min = 6'((c / 240) % 60);
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            if (ifc.last_tact_o === 1'b1) pulses++;
            if (ifc.min_o !== pm && !(ps == 6'd59 && ifc.sec_o == 6'd0)) viol++;
            ps = ifc.sec_o;
            pm = ifc.min_o;
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL run_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL run_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL run_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
        end
        total++; if (pulses != 3600) begin bad++; $display("FAIL run_pulses got=%0d exp=3600", pulses); end
        total++; if (viol != 0) begin bad++; $display("FAIL run_min_without_wrap got=%0d exp=0", viol); end
        total++; if (ifc.sec_o !== 6'd0 || ifc.min_o !== 6'd0) begin bad++; $display("FAIL run_end got=%0d:%0d exp=0:0", ifc.min_o, ifc.sec_o); end
    endtask

    task test_setting;
        exp_t e;
        ifc.user_time_val_i = 1'b1;
        for (int i = 0; i < 59; i++) begin
            ifc.user_min_up_i = 1'b1;
            repeat (3) @(negedge clk);
            ifc.user_min_up_i = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (ifc.min_o !== 6'd59) begin bad++; $display("FAIL set_preload_min got=%0d exp=59", ifc.min_o); end
        ifc.user_min_up_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            e.lt  = 1'b0;
            e.sec = 6'd0;
            e.min = (c < 3) ? 6'd59 : (c < 13) ? 6'd0 : 6'd1;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL set_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL set_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL set_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
            ifc.user_min_up_i = (c < 6) || (c >= 10 && c < 14);
        end
    endtask

    task test_release;
        exp_t e;
        ifc.user_time_val_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            e.lt  = (c == 3);
            e.sec = (c == 4) ? 6'd1 : 6'd0;
            e.min = 6'd1;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL rls_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL rls_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL rls_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
        end
    endtask

    task test_simultaneous;
        exp_t e;
        for (int c = 1; c <= 12; c++) begin
            e.lt  = (c < 4) ? (c == 3) : (((c - 4) % 4) == 3);
            e.sec = (c < 4) ? 6'd1 : 6'((c - 4) / 4);
            e.min = 6'd1;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL sim_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL sim_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL sim_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
            if (c == 3) begin
                ifc.user_time_val_i = 1'b1;
                #1;
                total++; if (ifc.last_tact_o !== 1'b0) begin bad++; $display("FAIL sim_lt_masked got=%0b exp=0", ifc.last_tact_o); end
            end
            if (c == 4) begin
                ifc.user_time_val_i = 1'b0;
                ifc.user_min_up_i = 1'b1;
            end
            if (c == 8) ifc.user_min_up_i = 1'b0;
        end
    endtask

    task test_async_reset;
        exp_t e;
        ifc.user_time_val_i = 1'b1;
        ifc.user_min_up_i = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (ifc.sec_o !== 6'd58) begin bad++; $display("FAIL arst_sec got=%0d exp=58", ifc.sec_o); end
        total++; if (ifc.min_o !== 6'd59) begin bad++; $display("FAIL arst_min got=%0d exp=59", ifc.min_o); end
        total++; if (ifc.last_tact_o !== 1'b0) begin bad++; $display("FAIL arst_lt got=%0b exp=0", ifc.last_tact_o); end
        @(negedge clk);
        ifc.user_min_up_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            e.lt  = 1'b0;
            e.sec = 6'd0;
            e.min = 6'd59;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            total++; if (ifc.last_tact_o !== e.lt) begin bad++; $display("FAIL arst_rel_lt cyc=%0d got=%0b exp=%0b", c, ifc.last_tact_o, e.lt); end
            total++; if (ifc.sec_o !== e.sec) begin bad++; $display("FAIL arst_rel_sec cyc=%0d got=%0d exp=%0d", c, ifc.sec_o, e.sec); end
            total++; if (ifc.min_o !== e.min) begin bad++; $display("FAIL arst_rel_min cyc=%0d got=%0d exp=%0d", c, ifc.min_o, e.min); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_setting();
        test_release();
        test_simultaneous();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
